source_read_4_16: RTL and testbench
===================================

Name: source_read_4_16

Overview:
- Read-side counterpart of the 4-RAM source capture path.
- Fetches one stored 944-byte raw frame (59 x 128-bit words) from one of the four source RAMs and re-serialises it as an 8-bit valid/ready byte stream.
- Frame index 0..15 selects the RAM (idx[3:2]) and the frame slot within that RAM (idx[1:0]).
- Sits between the source RAMs and downstream replay/processing logic.

Parameters:
- RD_LATENCY, 2, RAM read latency in cycles (1..4): rden high in cycle t means q is valid in cycle t+RD_LATENCY.
- FRAME_WORDS, 59, 128-bit words per frame; word address = {slot[1:0], word[5:0]}.

Ports:
- sys_clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- frame_req  input  1  start-of-read request; sampled only in IDLE
- frame_idx  input  4  frame to read: [3:2] RAM, [1:0] slot; latched on accept
- frame_busy  output  1  high from the cycle after accept until frame_done
- frame_done  output  1  one-cycle pulse after the last byte is transferred
- source_ram_rden  output  4  one-hot read enable, lane = latched RAM number
- source_ram_address  output  32  four 8-bit lanes, all carry the same word address
- source_ram_q  input  512  four 128-bit read-data lanes; lane n belongs to RAM n
- byte_out  output  8  serialised byte
- byte_valid  output  1  byte_out valid
- byte_ready  input  1  downstream accept; a transfer occurs when valid && ready
- byte_sof  output  1  qualifies the first byte of the frame
- byte_eof  output  1  qualifies byte 943
- checksum  output  8  frame checksum (optional feature)
- checksum_valid  output  1  checksum qualifier (optional feature)

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; word/byte counters, buffers and in-flight tracking cleared.
- FSM states: IDLE, FETCH, STREAM, DONE.
- IDLE: when frame_req=1, latch frame_idx, word_cnt=0, go to FETCH. frame_busy rises the next cycle.
- FETCH/STREAM read issue: rden[ram] and address={slot, word_cnt} are asserted for one cycle per read.
  - A read is issued when the prefetch slot is free (empty and no read in flight) and word_cnt < FRAME_WORDS.
  - At most one read is in flight. word_cnt increments on each issue.
- Capture: q lane[ram] is captured into the prefetch buffer RD_LATENCY cycles after issue.
  - The buffer moves to the shift register when the shift register is empty, or in the same cycle its 16th byte transfers.
- Byte order: bytes 0..15 of a word are [127:120] first, down to [7:0].
- First-byte latency: req sampled in cycle 0 -> rden in cycle 1 -> byte_valid in cycle 2+RD_LATENCY (cycle 4 at default).
- Throughput: with byte_ready held high, there are no bubbles between bytes within a frame.
- Handshake: while byte_valid=1 and byte_ready=0, byte_out, byte_sof and byte_eof hold stable. byte_valid never drops without a transfer.
- byte_sof=1 only with byte 0; byte_eof=1 only with byte 943 (word 58, byte 15).
- After the byte_eof transfer, enter DONE: frame_done=1 for one cycle, frame_busy=0 the next cycle, return to IDLE.
- frame_req asserted while busy is ignored; no queueing.
- frame_req in the DONE cycle is ignored; it is accepted from IDLE in the following cycle.
- Address wrap: word index never exceeds FRAME_WORDS-1 (58); the slot field is never modified.
- rden is never asserted outside FETCH/STREAM, and never to a RAM other than the latched one.

Optional Feature:
- SOURCE_READ_CHKSUM_EN defined:
  - checksum = mod-256 sum of all 944 transferred bytes; the accumulator clears on frame accept.
  - checksum_valid=1 in the same cycle as frame_done, with checksum stable until the next accept.
- SOURCE_READ_CHKSUM_EN undefined: checksum and checksum_valid are tied to 0 and no accumulator logic is present.

Test Plan:
- Reset, then frame_req with idx=4'b0110, RAM model word w = {16 bytes of (w+1)}, ready=1 -> rden=4'b0010 with addresses 8'h80..8'hBA in order; first byte_valid at cycle 4; 944 gapless bytes; sof on byte 0, eof on byte 943; frame_done one cycle later.
- Byte-order check: word0 = 128'h000102..0F -> byte_out sequence 00,01,...,0F.
- Backpressure: toggle byte_ready randomly at 50% -> byte_out stable while stalled; exactly 944 transfers; never two reads in flight.
- frame_req pulsed mid-frame with idx=4'hF -> ignored; no rden on lane 3; current frame completes unchanged.
- rst_n asserted at byte 500 -> all outputs 0 asynchronously; after release, a new request for idx=0 streams correctly from byte 0.
- SOURCE_READ_CHKSUM_EN defined, all bytes 8'h01 -> checksum=8'hB0 (944 mod 256) with checksum_valid coincident with frame_done; undefined -> both 0.

Source files
------------

// File: rtl/source_read_4_16.sv
// source_read_4_16
//   Reads one stored 944-byte raw frame (FRAME_WORDS x 128-bit words) from one
//   of four source RAMs and re-serialises it as an 8-bit valid/ready stream.
//   frame_idx[3:2] picks the RAM, frame_idx[1:0] the frame slot inside it.
//
// Ports
//   sys_clk, rst_n          clock, asynchronous active-low reset
//   frame_req, frame_idx    read request (sampled in IDLE) and frame index
//   frame_busy, frame_done  frame in progress / one-cycle completion pulse
//   source_ram_rden         one-hot read enable towards the four RAMs
//   source_ram_address      four 8-bit address lanes {slot, word}
//   source_ram_q            four 128-bit read-data lanes (lane n = RAM n)
//   byte_out, byte_valid,   byte stream with valid/ready handshake
//   byte_ready
//   byte_sof, byte_eof      first / last byte qualifiers
//   checksum,               mod-256 byte sum of the frame and its qualifier,
//   checksum_valid          present only with SOURCE_READ_CHKSUM_EN defined,
//                           otherwise tied to zero
module source_read_4_16 #(
  parameter int unsigned RD_LATENCY  = 2,
  parameter int unsigned FRAME_WORDS = 59
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         frame_req,
  input  logic [3:0]   frame_idx,
  output logic         frame_busy,
  output logic         frame_done,
  output logic [3:0]   source_ram_rden,
  output logic [31:0]  source_ram_address,
  input  logic [511:0] source_ram_q,
  output logic [7:0]   byte_out,
  output logic         byte_valid,
  input  logic         byte_ready,
  output logic         byte_sof,
  output logic         byte_eof,
  output logic [7:0]   checksum,
  output logic         checksum_valid
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM,
    DONE
  } state_e;

  localparam logic [6:0] FRAME_WORDS_W = 7'(FRAME_WORDS);
  localparam logic [9:0] LAST_BYTE     = 10'(FRAME_WORDS * 16 - 1);
  localparam logic [2:0] LAT           = 3'(RD_LATENCY);

  state_e       state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [6:0]   word_cnt_q, word_cnt_d;
  logic [2:0]   lat_q, lat_d;
  logic [127:0] pf_q, pf_d;
  logic         pf_vld_q, pf_vld_d;
  logic [127:0] sh_q, sh_d;
  logic [4:0]   sh_cnt_q, sh_cnt_d;
  logic [9:0]   byte_cnt_q, byte_cnt_d;

  logic         accept;
  logic         active;
  logic         issue;
  logic         capture;
  logic         xfer;
  logic         sh_free;
  logic [127:0] q_lane;

  // Read-data lane of the latched RAM
  always_comb begin
    q_lane = source_ram_q[127:0];
    case (idx_q[3:2])
      2'd0: q_lane = source_ram_q[127:0];
      2'd1: q_lane = source_ram_q[255:128];
      2'd2: q_lane = source_ram_q[383:256];
      2'd3: q_lane = source_ram_q[511:384];
      default: q_lane = source_ram_q[127:0];
    endcase
  end

  always_comb begin
    accept  = (state_q == IDLE) && frame_req;
    active  = (state_q == FETCH) || (state_q == STREAM);
    // lat_q counts down to the capture cycle; nonzero means a read is in flight
    issue   = active && !pf_vld_q && (lat_q == '0) && (word_cnt_q < FRAME_WORDS_W);
    capture = (lat_q == 3'd1);
    xfer    = byte_valid && byte_ready;
    // Shift register can take a new word now, or as its 16th byte leaves
    sh_free = (sh_cnt_q == '0) || (xfer && (sh_cnt_q == 5'd1));
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_cnt_d = word_cnt_q;
    lat_d      = lat_q;
    pf_d       = pf_q;
    pf_vld_d   = pf_vld_q;
    sh_d       = sh_q;
    sh_cnt_d   = sh_cnt_q;
    byte_cnt_d = byte_cnt_q;

    if (lat_q != '0) begin
      lat_d = lat_q - 3'd1;
    end
    if (issue) begin
      lat_d      = LAT;
      word_cnt_d = word_cnt_q + 7'd1;
    end

    if (xfer) begin
      sh_d       = {sh_q[119:0], 8'h00};
      sh_cnt_d   = sh_cnt_q - 5'd1;
      byte_cnt_d = byte_cnt_q + 10'd1;
    end

    // Returning data bypasses the prefetch buffer when the shift register is
    // free and nothing is waiting ahead of it; this keeps first-byte latency
    // at 2+RD_LATENCY and the stream gapless.
    if (sh_free) begin
      if (pf_vld_q) begin
        sh_d     = pf_q;
        sh_cnt_d = 5'd16;
        pf_vld_d = 1'b0;
      end else if (capture) begin
        sh_d     = q_lane;
        sh_cnt_d = 5'd16;
      end
    end
    if (capture && !(sh_free && !pf_vld_q)) begin
      pf_d     = q_lane;
      pf_vld_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d      = frame_idx;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (xfer && byte_eof) begin
          state_d = DONE;
        end else if (byte_valid) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer && byte_eof) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      word_cnt_q <= '0;
      lat_q      <= '0;
      pf_q       <= '0;
      pf_vld_q   <= 1'b0;
      sh_q       <= '0;
      sh_cnt_q   <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      word_cnt_q <= word_cnt_d;
      lat_q      <= lat_d;
      pf_q       <= pf_d;
      pf_vld_q   <= pf_vld_d;
      sh_q       <= sh_d;
      sh_cnt_q   <= sh_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  always_comb begin
    frame_busy         = (state_q != IDLE);
    frame_done         = (state_q == DONE);
    source_ram_rden    = issue ? (4'b0001 << idx_q[3:2]) : '0;
    source_ram_address = issue ? {4{idx_q[1:0], word_cnt_q[5:0]}} : '0;
    byte_valid         = (sh_cnt_q != '0);
    byte_out           = sh_q[127:120];
    byte_sof           = byte_valid && (byte_cnt_q == '0);
    byte_eof           = byte_valid && (byte_cnt_q == LAST_BYTE);
  end

`ifdef SOURCE_READ_CHKSUM_EN
  logic [7:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (accept) begin
      chk_d = '0;
    end else if (xfer) begin
      chk_d = chk_q + byte_out;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  always_comb begin
    checksum       = chk_q;
    checksum_valid = (state_q == DONE);
  end
`else
  always_comb begin
    checksum       = '0;
    checksum_valid = 1'b0;
  end
`endif

endmodule

// File: tb/tb_source_read_4_16.sv
module tb_source_read_4_16;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned NONE   = 9999;

  logic         clk;
  logic         rst_n;
  logic         frame_req;
  logic [3:0]   frame_idx;
  logic         frame_busy;
  logic         frame_done;
  logic [3:0]   rden;
  logic [31:0]  addr;
  logic [511:0] ram_q;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         byte_ready;
  logic         byte_sof;
  logic         byte_eof;
  logic [7:0]   checksum;
  logic         checksum_valid;

  int           checks = 0;
  int           errors = 0;
  int unsigned  ram_mode = 0;

  source_read_4_16 #(
    .RD_LATENCY  (RD_LAT),
    .FRAME_WORDS (59)
  ) dut (
    .sys_clk            (clk),
    .rst_n              (rst_n),
    .frame_req          (frame_req),
    .frame_idx          (frame_idx),
    .frame_busy         (frame_busy),
    .frame_done         (frame_done),
    .source_ram_rden    (rden),
    .source_ram_address (addr),
    .source_ram_q       (ram_q),
    .byte_out           (byte_out),
    .byte_valid         (byte_valid),
    .byte_ready         (byte_ready),
    .byte_sof           (byte_sof),
    .byte_eof           (byte_eof),
    .checksum           (checksum),
    .checksum_valid     (checksum_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents: mode 0 = word w filled with w+1, mode 1 = byte k of word w
  // is (16*w+k) mod 256, mode 2 = all 8'h01
  function automatic logic [127:0] content(input logic [7:0] a);
    logic [127:0] w;
    logic [5:0]   wi;
    wi = a[5:0];
    w  = '0;
    for (int k = 0; k < 16; k++) begin
      case (ram_mode)
        0:       w[127-8*k -: 8] = 8'(wi + 6'd1);
        1:       w[127-8*k -: 8] = {wi[3:0], 4'(k)};
        default: w[127-8*k -: 8] = 8'h01;
      endcase
    end
    return w;
  endfunction

  // Lanes not enabled return a marker pattern so a wrong lane select shows up
  logic [127:0] p1 [4];
  logic [127:0] p2 [4];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      p1[i] <= rden[i] ? content(addr[8*i +: 8]) : {16{8'hEE}};
      p2[i] <= p1[i];
    end
  end
  assign ram_q = {p2[3], p2[2], p2[1], p2[0]};

  function automatic logic [7:0] exp_byte(input int unsigned mode, input int unsigned n);
    case (mode)
      0:       return 8'(n / 16 + 1);
      1:       return 8'(n);
      default: return 8'h01;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, frame_busy, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_rden"}, rden, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_valid"}, byte_valid, 0);
    check({tag, "_byte"}, byte_out, 0);
    check({tag, "_sof"}, byte_sof, 0);
    check({tag, "_eof"}, byte_eof, 0);
    check({tag, "_ck"}, checksum, 0);
    check({tag, "_ckv"}, checksum_valid, 0);
  endtask

  task automatic run_frame(input logic [3:0] idx, input int unsigned mode,
                           input bit rand_rdy, input bit mid_req,
                           input bit done_req, input int unsigned abort_at);
    int unsigned n = 0;
    int unsigned word_exp = 0;
    int unsigned eof_c = 0;
    int unsigned last_issue = 0;
    bit          have_issue = 0;
    bit          first_seen = 0;
    bit          eof_seen = 0;
    bit          prev_stall = 0;
    bit          mid_done = 0;
    bit          finished = 0;
    bit          aborted = 0;
    logic [7:0]  prev_b = '0;
    logic        prev_sof = 0;
    logic        prev_eof = 0;
    logic [7:0]  sum = '0;
    logic [1:0]  ram;
    logic [1:0]  slot;
    ram  = idx[3:2];
    slot = idx[1:0];
    ram_mode = mode;

    @(negedge clk);
    frame_req  = 1'b1;
    frame_idx  = idx;
    byte_ready = 1'b1;

    for (int unsigned c = 1; c <= 6000 && !finished; c++) begin
      @(negedge clk);
      frame_req = 1'b0;
      if (c == 1) check("busy_rise", frame_busy, 1);

      if (rden != 0) begin
        check("rden_lane", rden, 4'b0001 << ram);
        check("word_bound", word_exp < 59, 1);
        check("rd_addr", addr, {4{slot, word_exp[5:0]}});
        if (have_issue) check("one_in_flight", (c - last_issue) >= RD_LAT, 1);
        have_issue = 1;
        last_issue = c;
        word_exp++;
      end

      if (!eof_seen) begin
        check("done_early", frame_done, 0);
        check("ckv_early", checksum_valid, 0);
        if (prev_stall) begin
          check("hold_valid", byte_valid, 1);
          check("hold_byte", byte_out, prev_b);
          check("hold_sof", byte_sof, prev_sof);
          check("hold_eof", byte_eof, prev_eof);
        end
        if (!rand_rdy && first_seen) check("gapless", byte_valid, 1);
        if (byte_valid) begin
          if (!first_seen) begin
            first_seen = 1;
            check("first_lat", c, 2 + RD_LAT);
          end
          check("byte", byte_out, exp_byte(mode, n));
          check("sof", byte_sof, n == 0);
          check("eof", byte_eof, n == 943);
        end

        if (abort_at != NONE && n == abort_at && byte_valid) begin
          rst_n = 1'b0;
          frame_req = 1'b0;
          #1;
          check_all_zero("async_rst");
          @(negedge clk);
          rst_n = 1'b1;
          byte_ready = 1'b1;
          aborted = 1;
          finished = 1;
        end else begin
          if (mid_req && !mid_done && n == 300) begin
            frame_req = 1'b1;
            frame_idx = 4'hF;
            mid_done = 1;
          end
          byte_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
          prev_stall = byte_valid && !byte_ready;
          prev_b     = byte_out;
          prev_sof   = byte_sof;
          prev_eof   = byte_eof;
          if (byte_valid && byte_ready) begin
            sum = sum + exp_byte(mode, n);
            if (n == 943) begin
              eof_seen = 1;
              eof_c = c;
            end
            n++;
          end
        end
      end else if (c == eof_c + 1) begin
        check("done_pulse", frame_done, 1);
        check("done_busy", frame_busy, 1);
        check("done_rden", rden, 0);
        check("done_valid", byte_valid, 0);
`ifdef SOURCE_READ_CHKSUM_EN
        check("ck_valid", checksum_valid, 1);
        check("checksum", checksum, sum);
        if (mode == 2) check("checksum_b0", checksum, 8'hB0);
`else
        check("ck_off", checksum, 0);
        check("ckv_off", checksum_valid, 0);
`endif
        if (done_req) begin
          frame_req = 1'b1;
          frame_idx = 4'hA;
        end
      end else if (c == eof_c + 2) begin
        check("done_clear", frame_done, 0);
        check("busy_fall", frame_busy, 0);
        check("ckv_clear", checksum_valid, 0);
`ifdef SOURCE_READ_CHKSUM_EN
        check("ck_hold", checksum, sum);
`endif
      end else if (c == eof_c + 3) begin
        check("req_in_done_ignored", frame_busy, 0);
        check("idle_rden", rden, 0);
        finished = 1;
      end
    end

    check("frame_end_reached", finished, 1);
    if (!aborted) begin
      check("byte_total", n, 944);
      check("word_total", word_exp, 59);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    frame_req  = 1'b0;
    frame_idx  = '0;
    byte_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    // idx 6: RAM 1, slot 2 -> addresses 8'h80..8'hBA, word w filled with w+1
    run_frame(4'h6, 0, 0, 0, 0, NONE);
    // byte order 00,01,..,0F from word 0; request held in DONE is ignored
    run_frame(4'h9, 1, 0, 0, 1, NONE);
    // random backpressure with a mid-frame request for idx F
    run_frame(4'h3, 1, 1, 1, 0, NONE);
    // asynchronous reset at byte 500
    run_frame(4'hD, 1, 1, 0, 0, 500);
    check_all_zero("after_rst");
    // fresh request for idx 0 after the reset
    run_frame(4'h0, 1, 0, 0, 0, NONE);
    // all bytes 8'h01 -> checksum 8'hB0 when the checksum is built in
    run_frame(4'h5, 2, 0, 0, 0, NONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
